// File: rtl/fp_window_pkg.sv
// Shared types and helpers for the fp16 raster-to-window stage.
// Contents:
//   scan_state_e  scan position class (STREAM / PAD_COL / PAD_ROW)
//   coord_t       16-bit scan / image coordinate
//   FP_ZERO       +0.0 fill value (sliced to the pixel width by users)
//   fp_width()    pixel width from exponent and fraction widths
//   scan_class()  classify a scan position against the image bounds
package fp_window_pkg;

  typedef enum logic [1:0] {
    STREAM  = 2'd0,
    PAD_COL = 2'd1,
    PAD_ROW = 2'd2
  } scan_state_e;

  typedef logic [15:0] coord_t;

  localparam int FP_MAX_WIDTH = 64;

  // +0.0 in any IEEE-like format is all-zero bits; users take the low FP width bits.
  localparam logic [FP_MAX_WIDTH-1:0] FP_ZERO = 64'h0;

  function automatic int fp_width(input int exp_width, input int frac_width);
    return 1 + exp_width + frac_width;
  endfunction

  // Pad rows take priority: the whole virtual row below the image is padding,
  // including its columns beyond the right image edge.
  function automatic scan_state_e scan_class(input coord_t x, input coord_t y,
                                             input coord_t iw, input coord_t ih);
    scan_state_e cls;
    if (y >= ih) begin
      cls = PAD_ROW;
    end else if (x >= iw) begin
      cls = PAD_COL;
    end else begin
      cls = STREAM;
    end
    return cls;
  endfunction

endpackage

// File: rtl/window_generator_fp16_if.sv
// Pixel-in / window-out bundle of window_generator_fp16.
// Signals:
//   data_i   pixel from upstream          valid_i  data_i valid
//   ready_o  window stage accepts data_i
//   window_o WIN_H x WIN_W taps, [0][0] is the top-left tap
//   col_o    centre column                row_o    centre row
//   valid_o  window_o/col_o/row_o valid
// Modports: master = upstream/consumer side, slave = the window stage.
interface window_generator_fp16_if #(
  parameter int FP_W  = 16,
  parameter int WIN_H = 3,
  parameter int WIN_W = 3
);

  logic [FP_W-1:0]                         data_i;
  logic                                    valid_i;
  logic                                    ready_o;
  logic [WIN_H-1:0][WIN_W-1:0][FP_W-1:0]   window_o;
  logic [15:0]                             col_o;
  logic [15:0]                             row_o;
  logic                                    valid_o;

  modport master (
    output data_i,
    output valid_i,
    input  ready_o,
    input  window_o,
    input  col_o,
    input  row_o,
    input  valid_o
  );

  modport slave (
    input  data_i,
    input  valid_i,
    output ready_o,
    output window_o,
    output col_o,
    output row_o,
    output valid_o
  );

endinterface

// File: rtl/fp_line_buffer.sv
// Circular delay line used to hold one virtual scan row of pixels.
// Every shift_en cycle it presents the sample written DEPTH enables ago on
// dout and overwrites that slot with din; the pointer wraps at DEPTH-1.
// Ports:
//   clk_i     clock
//   rst_i     asynchronous active-low reset (pointer only; contents are don't-care)
//   shift_en  advance the delay line by one sample
//   din       sample entering the line
//   dout      sample leaving the line (asynchronous read at the pointer)
module fp_line_buffer #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int              PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] ptr_r;

  // Read/write pointer: one slot per shift, wrapping at the last slot.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ptr_r <= {PTR_W{1'b0}};
    end else if (shift_en) begin
      ptr_r <= (ptr_r == PTR_LAST) ? {PTR_W{1'b0}} : ptr_r + PTR_ONE;
    end
  end

  // Storage: the oldest sample is replaced by the incoming one.
  always_ff @(posedge clk_i) begin
    if (shift_en) begin
      mem_r[ptr_r] <= din;
    end
  end

  assign dout = mem_r[ptr_r];

endmodule

// File: rtl/window_generator_fp16.sv
// Raster-to-window stage feeding the fp16 3x3 convolution wrappers.
// Accepts one pixel per handshake in raster order and emits one centred
// WINDOW_HEIGHT x WINDOW_WIDTH window per image pixel. The block walks a
// virtual scan of (IMAGE_WIDTH+HW) x (IMAGE_HEIGHT+HH) positions; positions
// outside the image are padding steps that run without input (ready_o low)
// so the last row/column of windows can be completed. Taps outside the
// image are forced to +0.0 by comparing their coordinates to the image bounds.
// Ports:
//   clk_i  clock
//   rst_i  asynchronous active-low reset
//   bus    window_generator_fp16_if slave: data_i/valid_i/ready_o in,
//          window_o/col_o/row_o/valid_o out (all outputs registered)
module window_generator_fp16
  import fp_window_pkg::*;
#(
  parameter int EXP_WIDTH     = 5,
  parameter int FRAC_WIDTH    = 10,
  parameter int WINDOW_WIDTH  = 3,
  parameter int WINDOW_HEIGHT = 3,
  parameter int IMAGE_WIDTH   = 640,
  parameter int IMAGE_HEIGHT  = 480
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  window_generator_fp16_if.slave  bus
);

  localparam int FP_WIDTH_REG = fp_width(EXP_WIDTH, FRAC_WIDTH);
  localparam int WW           = WINDOW_WIDTH;
  localparam int WH           = WINDOW_HEIGHT;
  localparam int HW           = WINDOW_WIDTH / 2;
  localparam int HH           = WINDOW_HEIGHT / 2;
  localparam int LB_DEPTH     = IMAGE_WIDTH + HW;

  localparam coord_t IW_C   = coord_t'(IMAGE_WIDTH);
  localparam coord_t IH_C   = coord_t'(IMAGE_HEIGHT);
  localparam coord_t HW_C   = coord_t'(HW);
  localparam coord_t HH_C   = coord_t'(HH);
  localparam coord_t X_LAST = coord_t'(IMAGE_WIDTH + HW - 1);
  localparam coord_t Y_LAST = coord_t'(IMAGE_HEIGHT + HH - 1);

  localparam logic [FP_WIDTH_REG-1:0] ZERO_PIX = FP_ZERO[FP_WIDTH_REG-1:0];

  typedef logic [WH-1:0][WW-1:0][FP_WIDTH_REG-1:0] win_t;

  scan_state_e             state_r;
  scan_state_e             state_next_s;
  coord_t                  x_r;
  coord_t                  y_r;
  coord_t                  x_next_s;
  coord_t                  y_next_s;
  logic                    ready_r;
  logic                    step_s;
  logic                    emit_s;
  logic [FP_WIDTH_REG-1:0] pix_s;
  logic [FP_WIDTH_REG-1:0] lb_out_s [WH-1];
  logic [FP_WIDTH_REG-1:0] col_in_s [WH];
  win_t                    taps_r;
  win_t                    taps_next_s;
  win_t                    win_masked_s;
  win_t                    win_r;
  logic                    valid_r;
  coord_t                  col_r;
  coord_t                  row_r;
  int                      tap_row_s;
  int                      tap_col_s;

  // Scan step qualification and the pixel entering the window for this step.
  always_comb begin
    step_s = 1'b0;
    pix_s  = ZERO_PIX;
    case (state_r)
      STREAM: begin
        step_s = bus.valid_i & ready_r;
        pix_s  = bus.data_i;
      end
      PAD_COL, PAD_ROW: begin
        step_s = 1'b1;
        pix_s  = ZERO_PIX;
      end
      default: begin
        // Unreachable encoding: keep stepping with zeros so the state is
        // re-derived from the coordinates on the next edge.
        step_s = 1'b1;
        pix_s  = ZERO_PIX;
      end
    endcase
  end

  // Next scan position and the state class of that position.
  always_comb begin
    x_next_s = x_r;
    y_next_s = y_r;
    if (step_s) begin
      if (x_r == X_LAST) begin
        x_next_s = 16'd0;
        if (y_r == Y_LAST) begin
          y_next_s = 16'd0;
        end else begin
          y_next_s = y_r + 16'd1;
        end
      end else begin
        x_next_s = x_r + 16'd1;
        y_next_s = y_r;
      end
    end else begin
      x_next_s = x_r;
      y_next_s = y_r;
    end
    state_next_s = scan_class(x_next_s, y_next_s, IW_C, IH_C);
  end

  // Scan state, position and input-ready registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= STREAM;
      x_r     <= 16'd0;
      y_r     <= 16'd0;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      x_r     <= x_next_s;
      y_r     <= y_next_s;
      ready_r <= (state_next_s == STREAM);
    end
  end

  // Line buffer chain: buffer k delays buffer k-1 by one full scan row.
  for (genvar k = 0; k < WH - 1; k++) begin : g_lb
    logic [FP_WIDTH_REG-1:0] lb_in_s;
    if (k == 0) begin : g_head
      assign lb_in_s = pix_s;
    end else begin : g_tail
      assign lb_in_s = lb_out_s[k-1];
    end
    fp_line_buffer #(
      .DEPTH (LB_DEPTH),
      .WIDTH (FP_WIDTH_REG)
    ) u_line (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .shift_en (step_s),
      .din      (lb_in_s),
      .dout     (lb_out_s[k])
    );
  end

  // New right-hand column: bottom tap row takes the live pixel, rows above
  // take progressively older scan rows from the line buffers.
  always_comb begin
    for (int i = 0; i < WH; i++) begin
      col_in_s[i] = ZERO_PIX;
    end
    col_in_s[WH-1] = pix_s;
    for (int k = 0; k < WH - 1; k++) begin
      col_in_s[WH-2-k] = lb_out_s[k];
    end
  end

  // Tap array after this step: shift left one column, append the new column.
  always_comb begin
    taps_next_s = taps_r;
    if (step_s) begin
      for (int i = 0; i < WH; i++) begin
        for (int j = 0; j < WW - 1; j++) begin
          taps_next_s[i][j] = taps_r[i][j+1];
        end
        taps_next_s[i][WW-1] = col_in_s[i];
      end
    end else begin
      taps_next_s = taps_r;
    end
  end

  // Tap array register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      taps_r <= '0;
    end else begin
      taps_r <= taps_next_s;
    end
  end

  // Coordinate masking: after the step at (x,y) the centre is (x-HW, y-HH),
  // so tap (i,j) covers image pixel (x-2HW+j, y-2HH+i). Anything outside the
  // image (including stale previous-row/previous-frame data) reads as +0.
  always_comb begin
    win_masked_s = '0;
    tap_row_s    = 0;
    tap_col_s    = 0;
    for (int i = 0; i < WH; i++) begin
      for (int j = 0; j < WW; j++) begin
        tap_row_s = int'(y_r) + i - 2 * HH;
        tap_col_s = int'(x_r) + j - 2 * HW;
        if ((tap_row_s >= 0) && (tap_row_s < IMAGE_HEIGHT) &&
            (tap_col_s >= 0) && (tap_col_s < IMAGE_WIDTH)) begin
          win_masked_s[i][j] = taps_next_s[i][j];
        end else begin
          win_masked_s[i][j] = ZERO_PIX;
        end
      end
    end
  end

  // A step emits once the centre lies inside the image (x>=HW, y>=HH).
  assign emit_s = step_s && (x_r >= HW_C) && (y_r >= HH_C);

  // Output registers: window and centre tag update only on an emitting step.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_r <= 1'b0;
      col_r   <= 16'd0;
      row_r   <= 16'd0;
      win_r   <= '0;
    end else begin
      valid_r <= emit_s;
      if (emit_s) begin
        col_r <= x_r - HW_C;
        row_r <= y_r - HH_C;
        win_r <= win_masked_s;
      end
    end
  end

  assign bus.ready_o  = ready_r;
  assign bus.valid_o  = valid_r;
  assign bus.col_o    = col_r;
  assign bus.row_o    = row_r;
  assign bus.window_o = win_r;

endmodule

// File: tb/tb_window_generator_fp16.sv
// Bench for window_generator_fp16 on a 4x3 image with a 3x3 window.
// Frames of formula or random pixels are streamed with several valid_i gap
// patterns; every emitted window is compared with one built directly from
// the stored frame with zero padding, in raster order per frame.
module tb_window_generator_fp16;

  localparam int IW      = 4;
  localparam int IH      = 3;
  localparam int WW      = 3;
  localparam int WH      = 3;
  localparam int HW      = WW / 2;
  localparam int HH      = WH / 2;
  localparam int FRAME_N = IW * IH;
  localparam int MAXF    = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks   = 0;
  int failures = 0;

  logic [15:0] pix [MAXF][IH][IW];

  int emit_k   = 0;
  int epoch_f  = 0;
  int run_len  = 0;
  int run_idx  = 0;
  bit armed    = 1'b0;
  bit gap_prev = 1'b0;

  window_generator_fp16_if #(.FP_W(16), .WIN_H(WH), .WIN_W(WW)) bus ();

  window_generator_fp16 #(
    .EXP_WIDTH     (5),
    .FRAC_WIDTH    (10),
    .WINDOW_WIDTH  (WW),
    .WINDOW_HEIGHT (WH),
    .IMAGE_WIDTH   (IW),
    .IMAGE_HEIGHT  (IH)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_tap(input int f, input int row, input int col,
                                          input int i, input int j);
    int rr;
    int cc;
    rr = row + i - HH;
    cc = col + j - HW;
    if (rr < 0 || rr >= IH || cc < 0 || cc >= IW) return 16'h0000;
    return pix[f][rr][cc];
  endfunction

  // Expected length of the k-th ready_o-low run in a frame: one pad column per
  // row, and on the last row also the whole pad row below the image.
  function automatic int exp_run(input int k);
    if ((k % IH) == IH - 1) return HW + HH * (IW + HW);
    return HW;
  endfunction

  // Remember whether this edge was an idle stream cycle (no step possible).
  always @(posedge clk) begin
    gap_prev <= rst && bus.ready_o && !bus.valid_i;
  end

  // Output monitor: window scoreboard, idle-cycle check and pad-run lengths.
  always @(negedge clk) begin
    int f;
    int pos;
    int ec;
    int er;
    if (rst) begin
      if (gap_prev) check_val("gap_valid", 64'(bus.valid_o), 64'd0);
      if (bus.valid_o) begin
        f   = epoch_f + emit_k / FRAME_N;
        pos = emit_k % FRAME_N;
        ec  = pos % IW;
        er  = pos / IW;
        if (f >= MAXF) begin
          check_val("extra_window", 64'(emit_k), 64'd0);
        end else begin
          check_val("col", 64'(bus.col_o), 64'(ec));
          check_val("row", 64'(bus.row_o), 64'(er));
          for (int i = 0; i < WH; i++) begin
            for (int j = 0; j < WW; j++) begin
              check_val($sformatf("win[%0d][%0d]@(%0d,%0d)f%0d", i, j, ec, er, f),
                        64'(bus.window_o[i][j]), 64'(exp_tap(f, er, ec, i, j)));
            end
          end
        end
        emit_k++;
      end
      if (bus.ready_o) begin
        if (armed && run_len > 0) begin
          check_val($sformatf("pad_run%0d", run_idx), 64'(run_len), 64'(exp_run(run_idx)));
          run_idx++;
        end
        armed   = 1'b1;
        run_len = 0;
      end else if (armed) begin
        run_len++;
      end
    end
  end

  task automatic fill_frame(input int f, input bit rnd);
    for (int r = 0; r < IH; r++) begin
      for (int c = 0; c < IW; c++) begin
        if (rnd) pix[f][r][c] = 16'($urandom_range(1, 65535));
        else     pix[f][r][c] = 16'(256 * r + c + 1);
      end
    end
  endtask

  // Present one pixel and hold it until an edge with ready_o high takes it.
  task automatic send(input logic [15:0] d);
    int guard;
    guard = 0;
    bus.valid_i = 1'b1;
    bus.data_i  = d;
    while (bus.ready_o !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check_val("ready_timeout", 64'(guard), 64'd0);
    @(negedge clk);
  endtask

  // mode 0: continuous, 1: two idle cycles after each pixel, 2: random gaps.
  task automatic send_frame(input int f, input int mode, input int npix);
    int gaps;
    for (int idx = 0; idx < npix; idx++) begin
      send(pix[f][idx / IW][idx % IW]);
      gaps = (mode == 1) ? 2 : (mode == 2) ? int'($urandom_range(0, 3)) : 0;
      if (gaps > 0) begin
        bus.valid_i = 1'b0;
        repeat (gaps) @(negedge clk);
      end
    end
  endtask

  initial begin
    bus.valid_i = 1'b0;
    bus.data_i  = 16'h0000;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_valid", 64'(bus.valid_o), 64'd0);
    check_val("rst_ready", 64'(bus.ready_o), 64'd0);
    check_val("rst_col", 64'(bus.col_o), 64'd0);
    check_val("rst_row", 64'(bus.row_o), 64'd0);
    check_val("rst_window", 64'(|bus.window_o), 64'd0);

    @(negedge clk);
    rst = 1'b1;
    #1 check_val("ready_at_release", 64'(bus.ready_o), 64'd0);
    @(negedge clk);
    check_val("ready_after_clock", 64'(bus.ready_o), 64'd1);

    fill_frame(0, 1'b0);
    fill_frame(1, 1'b0);
    fill_frame(2, 1'b1);
    fill_frame(3, 1'b1);
    fill_frame(4, 1'b0);
    send_frame(0, 0, FRAME_N);
    send_frame(1, 1, FRAME_N);
    send_frame(2, 2, FRAME_N);
    send_frame(3, 0, FRAME_N);
    send_frame(4, 0, 7);
    bus.valid_i = 1'b0;
    @(negedge clk);
    #1;
    check_val("windows_before_reset", 64'(emit_k), 64'(4 * FRAME_N + 2));
    check_val("col_before_reset", 64'(bus.col_o), 64'd1);

    rst = 1'b0;
    #1;
    check_val("midrst_valid", 64'(bus.valid_o), 64'd0);
    check_val("midrst_ready", 64'(bus.ready_o), 64'd0);
    check_val("midrst_col", 64'(bus.col_o), 64'd0);
    check_val("midrst_row", 64'(bus.row_o), 64'd0);
    check_val("midrst_window", 64'(|bus.window_o), 64'd0);
    epoch_f = 5;
    emit_k  = 0;
    armed   = 1'b0;
    run_len = 0;
    run_idx = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    fill_frame(5, 1'b0);
    fill_frame(6, 1'b1);
    send_frame(5, 0, FRAME_N);
    send_frame(6, 2, FRAME_N);
    bus.valid_i = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    check_val("windows_after_reset", 64'(emit_k), 64'(2 * FRAME_N));
    check_val("pad_runs_after_reset", 64'(run_idx), 64'(2 * IH));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/window_generator_fp16.md
Name: window_generator_fp16

Overview:
Raster-to-window stage directly upstream of the fp16 3x3 convolution wrappers (dx/dy kernels) in the dfdd pipeline. Accepts one fp16 pixel per handshake in raster order and emits one centred WINDOW_HEIGHT x WINDOW_WIDTH window per image pixel, with col_o/row_o/valid_o tagging the centre. Out-of-image taps are zero-filled (+0.0). The convolution has no backpressure, so this block absorbs all edge padding. It stalls its own input with ready_o while it inserts pad positions.

Parameters:
EXP_WIDTH, 5, fp exponent bits
FRAC_WIDTH, 10, fp fraction bits
WINDOW_WIDTH, 3, window columns (odd, >=3)
WINDOW_HEIGHT, 3, window rows (odd, >=3)
IMAGE_WIDTH, 640, pixels per row
IMAGE_HEIGHT, 480, rows per frame
FP_WIDTH_REG (local), 1+EXP_WIDTH+FRAC_WIDTH, pixel width; HW=WINDOW_WIDTH/2, HH=WINDOW_HEIGHT/2 (local)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-low
data_i  in  FP_WIDTH_REG  input pixel
valid_i  in  1  data_i valid
ready_o  out  1  block accepts data_i this cycle
window_o  out  FP_WIDTH_REG [WINDOW_HEIGHT][WINDOW_WIDTH]  window; [0][0] = top-left tap
col_o  out  16  centre column
row_o  out  16  centre row
valid_o  out  1  window_o/col_o/row_o valid

Behaviour:
- Reset (rst_i low, async): valid_o=0, ready_o=0, window_o all 0, col_o=0, row_o=0. Scan counters clear to (0,0) and FSM goes to STREAM. Line-buffer contents are don't-care. ready_o rises on the first clock after release.
- Virtual scan: x in 0..IMAGE_WIDTH+HW-1, y in 0..IMAGE_HEIGHT+HH-1, raster order, wraps to (0,0) for the next frame.
- FSM STREAM (x<IW, y<IH): ready_o=1. The scan advances only on valid_i&ready_o, and the accepted pixel is written at (x,y).
- FSM PAD_COL (x>=IW, y<IH): ready_o=0. The scan advances every cycle and writes +0.
- FSM PAD_ROW (y>=IH): ready_o=0. The scan advances every cycle and writes +0.
- Transitions follow the next (x,y) position. After the last scan position, the FSM returns to STREAM at (0,0).
- Storage: WINDOW_HEIGHT-1 line buffers, each of depth IMAGE_WIDTH+HW, plus a WINDOW_HEIGHT x WINDOW_WIDTH tap shift array. Each scan step shifts all of them.
- Output: on a scan step at (x,y) with x>=HW and y>=HH, the next cycle has valid_o=1, col_o=x-HW, row_o=y-HH. Latency is one cycle from the accepting edge to valid_o.
- Zero masking by coordinate: the tap for image pixel (col_o+j-HW, row_o+i-HH) outputs +0 when its column is <0 or >=IW, or its row is <0 or >=IH. This makes stale data from the previous row or frame invisible.
- Scan steps with centre x<HW or y<HH give valid_o=0, and all other outputs hold their last value.
- No step (STREAM with valid_i=0) gives valid_o=0, and state is unchanged.
- Throughput is one window per scan step. A frame takes exactly (IW+HW)(IH+HH) scan steps and produces IW*IH windows.
- Reset asserted mid-frame discards the partial frame. The first accepted pixel after reset is treated as (0,0).

Decomposition:
- Package fp_window_pkg:
  - scan-state enum {STREAM, PAD_COL, PAD_ROW}
  - FP_ZERO constant
  - fp width function of EXP_WIDTH/FRAC_WIDTH
  - 16-bit coordinate type
- Sub-module fp_line_buffer (DEPTH, WIDTH): circular RAM with a shift-enable input, 1-in/1-out per enable, pointer wraps at DEPTH-1. Instantiate it WINDOW_HEIGHT-1 times.

Test Plan:
(bench: IMAGE_WIDTH=4, IMAGE_HEIGHT=3, 3x3; pixel p(r,c)=16'h0100*r+c+1; scan is 5x4)
- Continuous valid_i=1 from reset:
  - 6th accept p(1,1) gives next cycle valid_o=1, col_o=0, row_o=0.
  - window row0 = 0,0,0; row1 = 0,p(0,0),p(0,1); row2 = 0,p(1,0),p(1,1).
- Row pad: after the 4th accept of each row, ready_o=0 for exactly 1 cycle.
  - During that pad step on row1, the window centred (3,0) is emitted with its right column all 0.
- Frame end: after accepting p(2,3), ready_o=0 for 6 cycles (1 col pad + 5-position pad row).
  - The last window is (3,2): centre=p(2,3), with the bottom row and right column 0.
  - There are 12 valid_o in total, and the frame takes 20 scan steps.
- Input gaps: valid_i toggled 1,0,0,1,... gives identical windows/col/row sequence to the continuous case, and valid_o=0 on gap cycles.
- Back-to-back frames: the second frame's window at (0,0) has its top row and left column 0, with no leakage of frame-1 data.
- Reset mid-frame: assert rst_i low after 7 accepts.
  - Outputs go to 0 immediately (async).
  - After release, a fresh frame reproduces the first-scenario window at (0,0).
